coin_dispenser: RTL and testbench

COIN_DISPENSER -- requirements
Module: coin_dispenser

---
 rtl/coin_dispenser_if.sv | 23 ++
 rtl/coin_dispenser.sv | 138 +++++++++++++
 tb/tb_coin_dispenser.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/coin_dispenser_if.sv
// Payout handshake between the vending controller (master) and the coin
// dispenser (slave): start/amount request, per-coin valid/ack, and status.
interface coin_dispenser_if;
  logic        I_START;
  logic [15:0] I_CHANGE_AMT;
  logic        I_COIN_ACK;
  logic        O_COIN_VALID;
  logic [2:0]  O_COIN_TYPE;
  logic        O_BUSY;
  logic        O_DONE;
  logic [15:0] O_REMAINING;
  logic        O_SHORT;

  modport master (
    output I_START, I_CHANGE_AMT, I_COIN_ACK,
    input  O_COIN_VALID, O_COIN_TYPE, O_BUSY, O_DONE, O_REMAINING, O_SHORT
  );

  modport slave (
    input  I_START, I_CHANGE_AMT, I_COIN_ACK,
    output O_COIN_VALID, O_COIN_TYPE, O_BUSY, O_DONE, O_REMAINING, O_SHORT
  );
endinterface

// File: rtl/coin_dispenser.sv
// Greedy change dispenser: pays out an amount one coin at a time, largest coin first.
// Optional per-denomination inventory with short-payout reporting: COIN_INVENTORY_EN.
module coin_dispenser #(
  parameter int INIT_COUNT = 16
) (
  input  logic            I_CLK,
  input  logic            I_RESET,
  coin_dispenser_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_t;

  state_t      r_state;
  logic        r_valid;
  logic [2:0]  r_type;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_rem;

  logic [5:0]  w_avail;
  logic [5:0]  w_fit;
  logic [2:0]  w_code;
  logic        w_found;

  function automatic logic [15:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 16'd1;
      3'd1:    coin_value = 16'd5;
      3'd2:    coin_value = 16'd10;
      3'd3:    coin_value = 16'd25;
      3'd4:    coin_value = 16'd100;
      3'd5:    coin_value = 16'd500;
      default: coin_value = 16'd0;
    endcase
  endfunction

`ifdef COIN_INVENTORY_EN
  logic        r_short;
  logic [15:0] r_inv [6];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < 6; i++) r_inv[i] <= 16'(INIT_COUNT);
    end else if (r_state == S_EJECT && bus.I_COIN_ACK) begin
      // selection only picks nonzero counters, so this cannot wrap
      r_inv[r_type] <= r_inv[r_type] - 16'd1;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_avail
    assign w_avail[gi] = (r_inv[gi] != 16'd0);
  end

  assign bus.O_SHORT = r_short;
`else
  assign w_avail     = 6'b111111;
  assign bus.O_SHORT = 1'b0;
`endif

  for (genvar gi = 0; gi < 6; gi++) begin : g_fit
    assign w_fit[gi] = w_avail[gi] && (coin_value(3'(gi)) <= r_rem);
  end

  // later (larger) denominations override earlier ones
  always_comb begin
    w_code  = 3'd0;
    w_found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_fit[i]) begin
        w_code  = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_type  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rem   <= 16'd0;
`ifdef COIN_INVENTORY_EN
      r_short <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.I_START) begin
            r_rem   <= bus.I_CHANGE_AMT;
            r_busy  <= 1'b1;
            r_state <= S_SELECT;
`ifdef COIN_INVENTORY_EN
            r_short <= 1'b0;
`endif
          end
        end
        S_SELECT: begin
          if (r_rem == 16'd0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_found) begin
            r_type  <= w_code;
            r_valid <= 1'b1;
            r_state <= S_EJECT;
          end else begin
`ifdef COIN_INVENTORY_EN
            r_short <= 1'b1;
`endif
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_EJECT: begin
          if (bus.I_COIN_ACK) begin
            r_rem   <= r_rem - coin_value(r_type);
            r_valid <= 1'b0;
            r_state <= S_SELECT;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.O_COIN_VALID = r_valid;
  assign bus.O_COIN_TYPE  = r_type;
  assign bus.O_BUSY       = r_busy;
  assign bus.O_DONE       = r_done;
  assign bus.O_REMAINING  = r_rem;

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: directed corner cases plus random
// payouts checked against a greedy change-making reference model.
module tb_coin_dispenser;

`ifdef COIN_INVENTORY_EN
  localparam int TB_INIT = 1;
  localparam bit INV_EN  = 1'b1;
`else
  localparam int TB_INIT = 16;
  localparam bit INV_EN  = 1'b0;
`endif
  localparam int VAL [6] = '{1, 5, 10, 25, 100, 500};
  localparam int BUDGET  = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int   inv [6];
  int   exp_q [$];
  int   exp_rem;
  bit   exp_short;

  coin_dispenser_if bus ();

  coin_dispenser #(.INIT_COUNT(TB_INIT)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 6; i++) inv[i] = TB_INIT;
  endtask

  // Greedy change-making over whatever coins are still in stock.
  task automatic model_payout(input int amt);
    int pick;
    exp_q.delete();
    exp_rem   = amt;
    exp_short = 1'b0;
    while (exp_rem > 0) begin
      pick = -1;
      for (int i = 0; i < 6; i++)
        if (VAL[i] <= exp_rem && (!INV_EN || inv[i] > 0)) pick = i;
      if (pick < 0) begin
        exp_short = 1'b1;
        break;
      end
      exp_q.push_back(pick);
      exp_rem -= VAL[pick];
      inv[pick]--;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.O_COIN_VALID), 0);
    chk({tag, "_type"},  32'(bus.O_COIN_TYPE),  0);
    chk({tag, "_busy"},  32'(bus.O_BUSY),       0);
    chk({tag, "_done"},  32'(bus.O_DONE),       0);
    chk({tag, "_rem"},   32'(bus.O_REMAINING),  0);
    chk({tag, "_short"}, 32'(bus.O_SHORT),      0);
  endtask

  task automatic run_payout(input int amt, input int max_delay, input bit inject);
    int cnt;
    int budget;
    int d;
    int run_rem;
    logic [2:0] held;
    model_payout(amt);
    @(negedge clk);
    bus.I_START      = 1'b1;
    bus.I_CHANGE_AMT = 16'(amt);
    @(negedge clk);
    bus.I_START = 1'b0;
    cnt     = 0;
    budget  = 0;
    run_rem = amt;
    forever begin
      if (bus.O_DONE) break;
      if (bus.O_COIN_VALID) begin
        held = bus.O_COIN_TYPE;
        if (cnt < exp_q.size()) chk("coin_type", 32'(held), 32'(exp_q[cnt]));
        else chk("extra_coin", 32'(cnt), 32'(exp_q.size()));
        d = $urandom_range(0, max_delay);
        if (inject && cnt == 0 && d < 2) d = 2;
        for (int s = 0; s < d; s++) begin
          if (inject && cnt == 0 && s == 0) begin
            bus.I_START      = 1'b1;
            bus.I_CHANGE_AMT = 16'd50;
          end
          @(negedge clk);
          bus.I_START = 1'b0;
          chk("stall_valid", 32'(bus.O_COIN_VALID), 1);
          chk("stall_type",  32'(bus.O_COIN_TYPE),  32'(held));
        end
        bus.I_COIN_ACK = 1'b1;
        @(negedge clk);
        bus.I_COIN_ACK = 1'b0;
        if (cnt < exp_q.size()) run_rem -= VAL[exp_q[cnt]];
        cnt++;
        chk("ack_valid_drop", 32'(bus.O_COIN_VALID), 0);
        chk("ack_remaining",  32'(bus.O_REMAINING),  32'(run_rem));
        budget = 0;
      end else begin
        @(negedge clk);
        budget++;
        if (budget > BUDGET) begin
          chk("timeout", 32'(budget), 32'(BUDGET));
          break;
        end
      end
    end
    chk("coin_count", 32'(cnt),             32'(exp_q.size()));
    chk("done_pulse", 32'(bus.O_DONE),      1);
    chk("done_busy",  32'(bus.O_BUSY),      1);
    chk("final_rem",  32'(bus.O_REMAINING), 32'(exp_rem));
    chk("final_short",32'(bus.O_SHORT),     32'(exp_short));
    @(negedge clk);
    chk("done_width", 32'(bus.O_DONE),      0);
    chk("idle_busy",  32'(bus.O_BUSY),      0);
    chk("hold_rem",   32'(bus.O_REMAINING), 32'(exp_rem));
    chk("hold_short", 32'(bus.O_SHORT),     32'(exp_short));
    $display("payout amt=%0d coins=%0d remaining=%0d short=%0b", amt, cnt, bus.O_REMAINING, bus.O_SHORT);
  endtask

  initial begin
    int budget;
    bus.I_START      = 1'b0;
    bus.I_CHANGE_AMT = 16'd0;
    bus.I_COIN_ACK   = 1'b0;
    reset_model();

    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    $display("reset applied");
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef COIN_INVENTORY_EN
    run_payout(50, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
`endif

    // zero amount: done two cycles after the start cycle, no coins
    @(negedge clk);
    bus.I_START      = 1'b1;
    bus.I_CHANGE_AMT = 16'd0;
    @(negedge clk);
    bus.I_START = 1'b0;
    chk("zero_c1_done",  32'(bus.O_DONE),       0);
    chk("zero_c1_valid", 32'(bus.O_COIN_VALID), 0);
    @(negedge clk);
    chk("zero_c2_done",  32'(bus.O_DONE),       1);
    chk("zero_c2_valid", 32'(bus.O_COIN_VALID), 0);
    chk("zero_c2_rem",   32'(bus.O_REMAINING),  0);
    @(negedge clk);
    chk("zero_c3_done",  32'(bus.O_DONE),       0);
    $display("payout amt=0 directed latency check");

    run_payout(141, 0, 1'b0);
    run_payout(1000, 5, 1'b0);
    run_payout(141, 3, 1'b1);

    // reset while a coin is presented; a late ack must do nothing
    @(negedge clk);
    bus.I_START      = 1'b1;
    bus.I_CHANGE_AMT = 16'd1000;
    @(negedge clk);
    bus.I_START = 1'b0;
    budget = 0;
    while (!bus.O_COIN_VALID && budget < BUDGET) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_valid_seen", 32'(bus.O_COIN_VALID), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.I_COIN_ACK = 1'b1;
    repeat (3) @(negedge clk);
    bus.I_COIN_ACK = 1'b0;
    check_all_zero("late_ack");
    reset_model();
    $display("mid-eject reset with late ack");

    for (int k = 0; k < 10; k++) run_payout($urandom_range(0, 1999), 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
